instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch block.
// Holds the default memory address width and buffer depth, plus the
// packed {instr, pc} entry carried through the fetch output buffer.
package fetch_pkg;

    // Default instruction-memory word-address width.
    localparam int IMEM_AW_DEF = 10;

    // Default number of output-buffer entries (power of two, >= 2).
    localparam int DEPTH_DEF = 2;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '0;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Purpose : FIFO-ordered output buffer of fetch_entry_t, head presented combinationally.
// Latency : a pushed entry is visible on head_o one edge later; a pop advances the head at the edge.
// Backpr. : no internal stall; the caller must not push when full (fetch control guarantees it).
//
// Ports:
//   clk_i, rstn_i        clock, synchronous active-low reset (clears pointers, count and storage)
//   push_i, push_dat_i   write an entry at the tail
//   pop_i                drop the head entry (ignored while empty)
//   flush_i              empty the buffer at the next edge; push/pop ignored that cycle
//   head_o               head entry, zero while empty
//   full_o, empty_o      occupancy flags
//   count_o              occupancy, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_pop;

    // A pop on an empty buffer is meaningless; drop it so the count cannot underflow.
    assign w_pop = pop_i & (r_count != '0);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= ENTRY_ZERO;
            end
        end else if (flush_i) begin
            // Storage contents are left as-is; an empty buffer never exposes them.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_tail] <= push_dat_i;
                r_tail        <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            // Push and pop together leave the occupancy unchanged.
            case ({push_i, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == DEPTH_L);
    assign count_o = r_count;
    assign head_o  = empty_o ? ENTRY_ZERO : r_mem[r_head];

endmodule : fetch_fifo

// File: rtl/instr_fetch.sv
// Purpose : Instruction fetch: issues one memory read per cycle while there is room, buffers results.
// Latency : issue to instr_valid_o is two edges with an empty buffer; one instruction per cycle sustained.
// Backpr. : issue stalls once buffered + in-flight entries would exceed DEPTH after this cycle's pop.
//
// Ports:
//   clk_i, rstn_i          clock, synchronous active-low reset
//   pc_i / pc_en_o         program-counter value and its increment enable (= issue)
//   imem_req_o/addr_o      memory read strobe and word address (pc_i truncated, wraps silently)
//   imem_rdata_i           read data, valid one cycle after imem_req_o
//   flush_i                drop buffered entries and kill the in-flight read
//   instr_valid_o/ready_i  downstream handshake
//   instr_o, instr_pc_o    head instruction and the pc_i value it was fetched at (0 when not valid)
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int IMEM_AW = IMEM_AW_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [31:0]        pc_i,
    output logic               pc_en_o,
    output logic               imem_req_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_rdata_i,
    input  logic               flush_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [31:0]        instr_o,
    output logic [31:0]        instr_pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    // In-flight read tracking: set in the cycle after an issue.
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;

    logic          w_pop;
    logic          w_issue;
    logic          w_push;
    logic          w_room;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_level;
    fetch_entry_t  w_push_dat;
    fetch_entry_t  w_head;

    // Downstream handshake. Valid is gated by reset so nothing is presented
    // even in the first reset cycle, before the buffer has been cleared.
    assign instr_valid_o = rstn_i & ~w_empty;
    assign w_pop         = instr_valid_o & instr_ready_i;
    assign instr_o       = instr_valid_o ? w_head.instr : 32'd0;
    assign instr_pc_o    = instr_valid_o ? w_head.pc    : 32'd0;

    // Entries committed for next cycle if nothing new is issued. A pop only
    // happens with occupancy > 0, so this never underflows.
    assign w_level = {1'b0, w_count}
                   + {{CW{1'b0}}, r_inflight}
                   - {{CW{1'b0}}, w_pop};

    // When full nothing can be in flight, so only a pop frees a slot.
    assign w_room  = w_full ? w_pop : (w_level < DEPTH_L);

    assign w_issue     = rstn_i & ~flush_i & w_room;
    assign pc_en_o     = w_issue;
    assign imem_req_o  = w_issue;
    assign imem_addr_o = pc_i[IMEM_AW-1:0];

    // Returning data is pushed the cycle after its issue; a flush in that
    // cycle kills it (the buffer also ignores pushes during flush).
    assign w_push           = r_inflight & ~flush_i;
    assign w_push_dat.instr = imem_rdata_i;
    assign w_push_dat.pc    = r_inflight_pc;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= pc_i;
            end
        end
    end

    fetch_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .push_i     (w_push),
        .push_dat_i (w_push_dat),
        .pop_i      (w_pop),
        .flush_i    (flush_i),
        .head_o     (w_head),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .count_o    (w_count)
    );

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (IMEM_AW=10, DEPTH=2).
// The bench plays program counter and instruction memory (data = 0xA000_0000 + addr),
// and an in-order scoreboard checks every accepted {pc, instr} pair.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [31:0] pc_i;
    logic        pc_en_o;
    logic        imem_req_o;
    logic [9:0]  imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        flush_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          pf_cnt = 0;
    logic        sb_on  = 1'b0;
    logic [31:0] exp_pc = 32'd0;

    always #5 clk = ~clk;

    instr_fetch #(
        .IMEM_AW       (10),
        .DEPTH         (2)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .pc_i          (pc_i),
        .pc_en_o       (pc_en_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .flush_i       (flush_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // No push may ever land in a full buffer.
    always @(negedge clk) begin
        if (rstn_i) begin
            a_no_push_full: assert (!(dut.u_fifo.push_i && dut.u_fifo.full_o))
                else pf_cnt++;
        end
    end

    // Called just after a negedge with inputs settled: samples the handshake,
    // crosses the next rising edge, then updates PC and memory data.
    task automatic tick();
        logic       en;
        logic       req;
        logic [9:0] a;
        en  = pc_en_o;
        req = imem_req_o;
        a   = imem_addr_o;
        if (sb_on && instr_valid_o && instr_ready_i) begin
            chk("sb_pc", instr_pc_o, exp_pc);
            chk("sb_instr", instr_o, 32'hA000_0000 + {22'd0, exp_pc[9:0]});
            exp_pc = exp_pc + 32'd1;
        end
        @(posedge clk);
        #1;
        if (en) pc_i = pc_i + 32'd1;
        imem_rdata_i = req ? (32'hA000_0000 + {22'd0, a}) : 32'hDEAD_BEEF;
    endtask

    // Two reset edges; returns just after the edge that starts cycle C0 with rstn_i=1.
    task automatic do_reset(input logic [31:0] start_pc, input logic rdy);
        rstn_i        = 1'b0;
        flush_i       = 1'b0;
        instr_ready_i = rdy;
        pc_i          = start_pc;
        sb_on         = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", instr_pc_o, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en_o}, 32'd0);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        rstn_i = 1'b1;
    endtask

    initial begin
        imem_rdata_i = 32'd0;

        // Stream from reset, ready held high.
        do_reset(32'd0, 1'b1);
        @(negedge clk);
        chk("c0_req", {31'd0, imem_req_o}, 32'd1);
        chk("c0_pc_en", {31'd0, pc_en_o}, 32'd1);
        chk("c0_addr", {22'd0, imem_addr_o}, 32'd0);
        chk("c0_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        @(negedge clk);
        chk("c1_req", {31'd0, imem_req_o}, 32'd1);
        chk("c1_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        @(negedge clk);
        chk("c2_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("c2_instr", instr_o, 32'hA000_0000);
        chk("c2_pc", instr_pc_o, 32'd0);
        exp_pc = 32'd0;
        sb_on  = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("run_req", {31'd0, imem_req_o}, 32'd1);
            tick();
        end
        chk("run_thruput", exp_pc, 32'd8);

        // Backpressure: ready low from reset, then 5 stalled cycles once valid.
        do_reset(32'd0, 1'b0);
        @(negedge clk); tick();
        @(negedge clk); tick();
        @(negedge clk);
        chk("bp_pc_en", {31'd0, pc_en_o}, 32'd0);
        chk("bp_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("bp_instr", instr_o, 32'hA000_0000);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_pc_en", {31'd0, pc_en_o}, 32'd0);
            chk("bp_hold_instr", instr_o, 32'hA000_0000);
            chk("bp_hold_pc", instr_pc_o, 32'd0);
            chk("bp_count", 32'(dut.u_fifo.count_o), 32'd2);
            tick();
        end
        chk("bp_pc_stall", pc_i, 32'd2);
        instr_ready_i = 1'b1;
        exp_pc = 32'd0;
        sb_on  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tick();
        end
        chk("bp_drain", exp_pc, 32'd8);

        // Flush: first with one entry buffered and one read in flight (killed),
        // then with the buffer full (DEPTH=2 leaves no room for a third read).
        do_reset(32'd0, 1'b0);
        @(negedge clk); tick();
        @(negedge clk); tick();
        flush_i = 1'b1;
        @(negedge clk);
        chk("fl1_req", {31'd0, imem_req_o}, 32'd0);
        chk("fl1_pc_en", {31'd0, pc_en_o}, 32'd0);
        chk("fl1_valid_before", {31'd0, instr_valid_o}, 32'd1);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        chk("fl1_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("fl1_instr", instr_o, 32'd0);
        chk("fl1_pc", instr_pc_o, 32'd0);
        chk("fl1_resume_req", {31'd0, imem_req_o}, 32'd1);
        chk("fl1_resume_addr", {22'd0, imem_addr_o}, 32'd2);
        tick();
        @(negedge clk); tick();
        @(negedge clk); tick();
        flush_i = 1'b1;
        @(negedge clk);
        chk("fl2_valid_before", {31'd0, instr_valid_o}, 32'd1);
        chk("fl2_head_pc", instr_pc_o, 32'd2);
        chk("fl2_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        flush_i       = 1'b0;
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("fl2_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("fl2_instr", instr_o, 32'd0);
        chk("fl2_resume_addr", {22'd0, imem_addr_o}, 32'd4);
        exp_pc = 32'd4;
        sb_on  = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tick();
        end
        chk("fl_drain", exp_pc, 32'd8);

        // Address wrap at 2^10.
        do_reset(32'h0000_03FF, 1'b1);
        @(negedge clk);
        chk("wr_addr0", {22'd0, imem_addr_o}, 32'h3FF);
        tick();
        @(negedge clk);
        chk("wr_addr1", {22'd0, imem_addr_o}, 32'h000);
        tick();
        @(negedge clk);
        chk("wr_pc0", instr_pc_o, 32'h3FF);
        chk("wr_instr0", instr_o, 32'hA000_03FF);
        tick();
        @(negedge clk);
        chk("wr_pc1", instr_pc_o, 32'h400);
        chk("wr_instr1", instr_o, 32'hA000_0000);
        tick();

        // One-edge reset pulse mid-stream (valid=1, read 0x402 in flight).
        rstn_i = 1'b0;
        @(negedge clk);
        chk("rp_valid_during", {31'd0, instr_valid_o}, 32'd0);
        chk("rp_req_during", {31'd0, imem_req_o}, 32'd0);
        chk("rp_instr_during", instr_o, 32'd0);
        tick();
        rstn_i = 1'b1;
        @(negedge clk);
        chk("rp_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rp_instr", instr_o, 32'd0);
        chk("rp_pc", instr_pc_o, 32'd0);
        chk("rp_req", {31'd0, imem_req_o}, 32'd1);
        chk("rp_addr", {22'd0, imem_addr_o}, 32'h003);
        exp_pc = 32'h403;
        sb_on  = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tick();
        end
        chk("rp_drain", exp_pc, 32'h407);

        // Alternating ready 1,0,1,0... for 20 cycles: pops on every even cycle from C2.
        do_reset(32'd0, 1'b1);
        exp_pc = 32'd0;
        sb_on  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr_ready_i = (i % 2 == 0);
            @(negedge clk);
            tick();
        end
        chk("alt_count", exp_pc, 32'd9);
        chk("no_push_full", 32'(pf_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_instr_fetch
